fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

- Round-robin scheduler between four 6-bit input FIFOs and four 6-bit output FIFOs of the same FIFO type.
- Each cycle it grants at most one non-empty input FIFO and issues its pop.
- It routes the returned word to the output FIFO selected by the word's two MSBs and issues that FIFO's push.
- It also holds the almost-empty/almost-full threshold configuration loaded during an INIT phase.

## Interface
- DATA_WIDTH, 6, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination index
- NUM_CH, 4, input and output channel count (fixed at 4; the 2-bit destination field depends on it)
- TH_WIDTH, 5, width of each threshold register
- clk  in  1  clock; all logic on rising edge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  requests the INIT (configuration) state
- umbral_ae_in  in  TH_WIDTH  almost-empty threshold, captured in INIT
- umbral_af_in  in  TH_WIDTH  almost-full threshold, captured in INIT
- empty_in  in  NUM_CH  Fifo_Empty of each input FIFO
- data_in  in  NUM_CH*DATA_WIDTH  Fifo_Data_out of each input FIFO; channel i occupies bits [6i+5:6i]
- pausa_out  in  NUM_CH  Pausa of each output FIFO
- full_out  in  NUM_CH  Fifo_Full of each output FIFO
- pop  out  NUM_CH  one-hot pop to the input FIFOs; registered
- push  out  NUM_CH  one-hot push to the output FIFOs; registered
- data_out  out  DATA_WIDTH  word to the output FIFOs; registered
- umbral_ae, umbral_af  out  TH_WIDTH  configured thresholds
- state  out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3
- idle  out  1  high exactly when state==IDLE
- error  out  1  sticky overflow-drop flag

## Operation
- **Reset (reset_L low):** state=RESET. pop=0, push=0, data_out=0, umbral_ae=0, umbral_af=0, idle=0, error=0. Round-robin pointer=3, so channel 0 has first priority.
- **RESET → INIT:** on the first edge after reset_L rises.
- **INIT:**
  - umbral_ae and umbral_af load from their inputs every cycle.
  - No pops are issued.
  - Leaves to IDLE on the first edge where init==0.
- **IDLE:**
  - init==1 → INIT.
  - Otherwise, any empty_in bit low → ACTIVE.
  - No pops are issued in IDLE.
- **ACTIVE, arbitration each cycle:**
  - Eligible channels: empty_in[i]==0, channel i was not popped in the previous cycle (the empty flag is one cycle stale), no pausa_out bit is high, and init==0.
  - Grant: the first eligible channel after the pointer, searching circularly.
  - pop[grant]=1 for one cycle, and the pointer updates to grant.
- **ACTIVE → INIT:** on init==1, taken only after the pipeline is empty. New pops stop immediately; in-flight words complete.
- **ACTIVE → IDLE:** all empty_in bits high and no word in flight.
- **Routing:**
  - The word read from data_in[grant] has destination dest = word[5:4].
  - If full_out[dest]==0: push[dest]=1 and data_out=word.
  - If full_out[dest]==1: the word is dropped, error is set, and push stays 0.
- **Backpressure:** any pausa_out bit high blocks all new pops. Pausa asserts at almost-full, so the up to 2 words already in flight still fit.
- **Error:** sticky; cleared only by reset or by entering INIT.

## Timing
- **Pop-to-push latency:** pop high in cycle t; FIFO output word valid in cycle t+1; push/data_out high in cycle t+2.
- **Throughput:** 1 word/cycle when at least two channels are non-empty. A single busy channel gets every other cycle.
- **push:** one-hot or zero. It pulses only for one cycle per word; data_out holds its last value when push=0.
- **pop and push together:** may be high in the same cycle for different words.
- **Reset mid-operation:** all outputs go to their reset values asynchronously; in-flight words are discarded.
- **init mid-pipeline:** thresholds change only in INIT, never while a word is in flight.

## Structure
- Shared package fifo_arb_pkg: state encodings (RESET, INIT, IDLE, ACTIVE), NUM_CH, destination-field bit positions.
- Sub-module rr_pick4: combinational 4-way circular priority pick. Inputs: request vector and pointer. Outputs: one-hot grant and a valid bit.
- Top level holds the FSM, pointer, in-flight pipeline registers and the routing/drop logic.

## Test plan
1. **Reset and init:** reset_L low, then release; hold init=1 with umbral_ae_in=1, umbral_af_in=3, then drop init.
   - Expect state RESET→INIT→IDLE, umbral_ae=1, umbral_af=3, all pops/pushes 0 throughout.
2. **Single word:** channel 2 non-empty holding 6'b01_0101.
   - pop=4'b0100 at t; push=4'b0010 and data_out=6'h15 at t+2; state returns to IDLE.
3. **Round robin:** all four channels non-empty continuously.
   - Grant order 0,1,2,3,0 on consecutive cycles; no channel popped on back-to-back cycles.
4. **Backpressure:** pausa_out[1]=1 while channels 0 and 3 are non-empty.
   - No pop while it is high; pending in-flight words still pushed; pops resume the cycle after it drops.
5. **Overflow drop:** word 6'b11_0000 routed while full_out[3]=1.
   - push stays 0 and error=1; error stays high until an INIT pass.
6. **Reset mid-pipeline:** assert reset_L low the cycle after a pop.
   - push never fires; all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the four-channel FIFO round-robin arbiter.
package fifo_arb_pkg;

    localparam int NUM_CH         = 4;
    localparam int DEST_W         = 2;
    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_TH_WIDTH   = 5;

    // The destination field occupies the DEST_W most significant bits of a word.
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } arb_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way circular priority pick: first requester strictly after ptr wins,
// with ptr itself searched last.
module rr_pick4
    import fifo_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic              valid
);

    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = ptr + 2'(k);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler moving words from four input FIFOs to four output
// FIFOs, routed by the word's destination field.
//
//   state  | meaning
//   RESET  | outputs cleared, waiting for first edge after reset release
//   INIT   | thresholds track their inputs, no pops, error cleared
//   IDLE   | all inputs empty, no pops
//   ACTIVE | arbitrating one pop per cycle, draining the read pipeline
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TH_WIDTH   = DEF_TH_WIDTH
)(
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic                         init,
    input  logic [TH_WIDTH-1:0]          umbral_ae_in,
    input  logic [TH_WIDTH-1:0]          umbral_af_in,
    input  logic [NUM_CH-1:0]            empty_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            pausa_out,
    input  logic [NUM_CH-1:0]            full_out,
    output logic [NUM_CH-1:0]            pop,
    output logic [NUM_CH-1:0]            push,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [TH_WIDTH-1:0]          umbral_ae,
    output logic [TH_WIDTH-1:0]          umbral_af,
    output logic [1:0]                   state,
    output logic                         idle,
    output logic                         error
);

    arb_state_t             st;
    logic [1:0]             ptr;
    logic                   rd_valid;
    logic [1:0]             rd_idx;
    logic [DATA_WIDTH-1:0]  ch_word [NUM_CH];
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DEST_W-1:0]      rd_dest;
    logic                   arb_en;
    logic                   in_flight;
    logic [NUM_CH-1:0]      req;
    logic [NUM_CH-1:0]      gnt;
    logic                   gnt_valid;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_word[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // A channel popped this cycle still shows a stale empty flag, so it sits out.
    assign arb_en    = (st == ST_ACTIVE) && !init && (pausa_out == '0);
    assign req       = arb_en ? (~empty_in & ~pop) : '0;
    assign rd_word   = ch_word[rd_idx];
    assign rd_dest   = rd_word[DATA_WIDTH-1 -: DEST_W];
    assign in_flight = (pop != '0) || rd_valid;
    assign state     = st;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (gnt),
        .valid (gnt_valid)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st        <= ST_RESET;
            pop       <= '0;
            push      <= '0;
            data_out  <= '0;
            umbral_ae <= '0;
            umbral_af <= '0;
            idle      <= 1'b0;
            error     <= 1'b0;
            ptr       <= 2'd3;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
        end else begin
            pop      <= gnt;
            rd_valid <= (pop != '0);
            rd_idx   <= ptr;
            if (gnt_valid) ptr <= onehot_to_idx(gnt);

            push <= '0;
            if (rd_valid) begin
                if (full_out[rd_dest]) begin
                    error <= 1'b1;
                end else begin
                    push     <= idx_to_onehot(rd_dest);
                    data_out <= rd_word;
                end
            end

            case (st)
                ST_RESET: begin
                    st   <= ST_INIT;
                    idle <= 1'b0;
                end
                ST_INIT: begin
                    umbral_ae <= umbral_ae_in;
                    umbral_af <= umbral_af_in;
                    error     <= 1'b0;
                    if (!init) begin
                        st   <= ST_IDLE;
                        idle <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        st    <= ST_INIT;
                        idle  <= 1'b0;
                        error <= 1'b0;
                    end else if (empty_in != '1) begin
                        st   <= ST_ACTIVE;
                        idle <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // init waits for the pipeline to drain so thresholds never move mid-word
                    if (init) begin
                        if (!in_flight) begin
                            st    <= ST_INIT;
                            error <= 1'b0;
                        end
                    end else if ((empty_in == '1) && !in_flight) begin
                        st   <= ST_IDLE;
                        idle <= 1'b1;
                    end
                end
                default: st <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with an in-bench reference model and
// registered-output input FIFO emulation.
module tb_fifo_rr_arbiter;

    localparam int DW = 6;
    localparam int TW = 5;
    localparam int NC = 4;

    logic            clk;
    logic            reset_L;
    logic            init;
    logic [TW-1:0]   umbral_ae_in;
    logic [TW-1:0]   umbral_af_in;
    logic [NC-1:0]   empty_in;
    logic [NC*DW-1:0] data_in;
    logic [NC-1:0]   pausa_out;
    logic [NC-1:0]   full_out;
    logic [NC-1:0]   pop;
    logic [NC-1:0]   push;
    logic [DW-1:0]   data_out;
    logic [TW-1:0]   umbral_ae;
    logic [TW-1:0]   umbral_af;
    logic [1:0]      state;
    logic            idle;
    logic            error;

    int checks = 0;
    int errors = 0;

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .TH_WIDTH(TW)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .umbral_ae_in (umbral_ae_in),
        .umbral_af_in (umbral_af_in),
        .empty_in     (empty_in),
        .data_in      (data_in),
        .pausa_out    (pausa_out),
        .full_out     (full_out),
        .pop          (pop),
        .push         (push),
        .data_out     (data_out),
        .umbral_ae    (umbral_ae),
        .umbral_af    (umbral_af),
        .state        (state),
        .idle         (idle),
        .error        (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] oh(input int ch);
        logic [NC-1:0] v;
        v = '0;
        if (ch >= 0) v[ch] = 1'b1;
        return v;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    int            m_state = 0, m_ptr = 3, m_pop = -1, m_rd = -1, m_push = -1;
    logic [DW-1:0] m_data = '0;
    logic          m_err = 1'b0;
    logic [TW-1:0] m_ae = '0, m_af = '0;
    int            cyc = 0;
    logic [NC-1:0] pop_log[$];
    logic [NC-1:0] push_log[$];
    int            pop_cyc[$];
    int            push_cyc[$];
    logic [DW-1:0] push_dat[$];

    always @(negedge clk) begin
        int            n_state, n_ptr, n_pop, n_push, c, dst;
        logic [DW-1:0] n_data, w;
        logic          n_err, busy;
        logic [TW-1:0] n_ae, n_af;
        cyc++;
        if (!reset_L) begin
            m_state = 0; m_ptr = 3; m_pop = -1; m_rd = -1; m_push = -1;
            m_data = '0; m_err = 1'b0; m_ae = '0; m_af = '0;
        end
        chk("pop", pop, oh(m_pop));
        chk("push", push, oh(m_push));
        chk("data_out", data_out, m_data);
        chk("state", state, m_state);
        chk("idle", idle, m_state == 2);
        chk("error", error, m_err);
        chk("umbral_ae", umbral_ae, m_ae);
        chk("umbral_af", umbral_af, m_af);
        if (pop != '0) begin pop_log.push_back(pop); pop_cyc.push_back(cyc); end
        if (push != '0) begin push_log.push_back(push); push_cyc.push_back(cyc); push_dat.push_back(data_out); end

        if (reset_L) begin
            n_pop = -1;
            if (m_state == 3 && !init && pausa_out == '0) begin
                for (int k = 1; k <= NC; k++) begin
                    c = (m_ptr + k) % NC;
                    if (n_pop < 0 && !empty_in[c] && c != m_pop) n_pop = c;
                end
            end
            n_ptr  = (n_pop >= 0) ? n_pop : m_ptr;
            n_push = -1;
            n_data = m_data;
            n_err  = m_err;
            if (m_rd >= 0) begin
                w   = data_in[m_rd*DW +: DW];
                dst = int'(w) / 16;
                if (full_out[dst]) n_err = 1'b1;
                else begin n_push = dst; n_data = w; end
            end
            busy    = (m_pop >= 0) || (m_rd >= 0);
            n_state = m_state;
            n_ae    = m_ae;
            n_af    = m_af;
            case (m_state)
                0: n_state = 1;
                1: begin
                    n_ae = umbral_ae_in; n_af = umbral_af_in; n_err = 1'b0;
                    if (!init) n_state = 2;
                end
                2: if (init) n_state = 1; else if (empty_in != 4'hF) n_state = 3;
                default: if (init) begin if (!busy) n_state = 1; end
                         else if (empty_in == 4'hF && !busy) n_state = 2;
            endcase
            if (n_state == 1 && m_state != 1) n_err = 1'b0;
            m_rd = m_pop; m_pop = n_pop; m_ptr = n_ptr; m_push = n_push;
            m_data = n_data; m_err = n_err; m_state = n_state; m_ae = n_ae; m_af = n_af;
        end
    end

    // ---------------- input FIFO emulation (registered read port) ----------------
    logic [DW-1:0] fq [NC][$];
    logic [DW-1:0] dreg [NC];

    task automatic refresh();
        for (int i = 0; i < NC; i++) begin
            empty_in[i]         = (fq[i].size() == 0);
            data_in[i*DW +: DW] = dreg[i];
        end
    endtask

    task automatic load(input int ch, input logic [DW-1:0] w);
        fq[ch].push_back(w);
        refresh();
    endtask

    task automatic tick();
        logic [NC-1:0] p;
        @(negedge clk);
        p = pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (p[i] && fq[i].size() != 0) dreg[i] = fq[i].pop_front();
        end
        refresh();
        #1;
    endtask

    task automatic wait_pop(input string name, input int max);
        int n;
        n = 0;
        while (pop == '0 && n < max) begin tick(); n++; end
        chk(name, pop != '0, 1);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (state != 2'd2 && n < max) begin tick(); n++; end
        chk(name, state == 2'd2, 1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int b, bp, ps, d, cnt, first;
        logic [NC-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        reset_L = 1'b0; init = 1'b0; umbral_ae_in = '0; umbral_af_in = '0;
        pausa_out = '0; full_out = '0;
        for (int i = 0; i < NC; i++) dreg[i] = '0;
        refresh();
        repeat (3) tick();

        // reset release and INIT capture
        init = 1'b1; umbral_ae_in = 5'd1; umbral_af_in = 5'd3;
        reset_L = 1'b1;
        tick();
        chk("t1_state_init", state, 2'd1);
        tick(); tick();
        init = 1'b0;
        tick();
        chk("t1_state_idle", state, 2'd2);
        chk("t1_idle", idle, 1'b1);
        chk("t1_ae", umbral_ae, 5'd1);
        chk("t1_af", umbral_af, 5'd3);
        chk("t1_no_pops", pop_log.size(), 0);

        // round robin over four busy channels, pointer fresh from reset
        b = pop_log.size(); bp = push_log.size();
        for (int ch = 0; ch < NC; ch++) begin
            load(ch, {2'(ch ^ 1), 4'(ch)});
            load(ch, {2'(ch), 4'(ch + 8)});
        end
        tick(); tick();
        wait_idle("t3_idle_timeout", 40);
        chk("t3_pop_count", pop_log.size() - b, 8);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_grant%0d", i), pop_log[b+i], exp_seq[i]);
        cnt = 0;
        for (int i = 0; i < 7; i++) if (pop_cyc[b+i+1] != pop_cyc[b+i] + 1) cnt++;
        chk("t3_consecutive", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 7; i++) if (pop_log[b+i+1] == pop_log[b+i]) cnt++;
        chk("t3_back_to_back", cnt, 0);
        chk("t3_push_count", push_log.size() - bp, 8);

        // single word on channel 2
        b = pop_log.size(); bp = push_log.size();
        load(2, 6'b01_0101);
        wait_pop("t2_pop_timeout", 10);
        wait_idle("t2_idle_timeout", 10);
        chk("t2_pop", pop_log[b], 4'b0100);
        chk("t2_push", push_log[bp], 4'b0010);
        chk("t2_data", push_dat[bp], 6'h15);
        chk("t2_latency", push_cyc[bp] - pop_cyc[b], 2);
        chk("t2_state", state, 2'd2);

        // backpressure from one output FIFO
        b = pop_log.size(); bp = push_log.size();
        load(0, 6'h07); load(0, 6'h08); load(3, 6'h31); load(3, 6'h32);
        wait_pop("t4_pop_timeout", 10);
        ps = cyc + 1;
        pausa_out = 4'b0010;
        repeat (4) tick();
        d = cyc + 1;
        pausa_out = '0;
        wait_idle("t4_idle_timeout", 20);
        cnt = 0; first = -1;
        for (int i = b; i < pop_log.size(); i++) begin
            if (pop_cyc[i] > ps && pop_cyc[i] <= d) cnt++;
            if (pop_cyc[i] > ps && first < 0) first = pop_cyc[i];
        end
        chk("t4_no_pop_while_paused", cnt, 0);
        chk("t4_resume_cycle", first - d, 1);
        cnt = 0;
        for (int i = bp; i < push_log.size(); i++) if (push_cyc[i] > ps && push_cyc[i] <= d) cnt++;
        chk("t4_inflight_pushed", cnt, 1);
        chk("t4_push_count", push_log.size() - bp, 4);

        // overflow drop into a full output FIFO
        bp = push_log.size();
        full_out = 4'b1000;
        load(1, 6'b11_0000);
        wait_pop("t5_pop_timeout", 10);
        wait_idle("t5_idle_timeout", 10);
        chk("t5_no_push", push_log.size() - bp, 0);
        chk("t5_error", error, 1'b1);
        repeat (3) tick();
        chk("t5_error_sticky", error, 1'b1);
        init = 1'b1; umbral_ae_in = 5'd7; umbral_af_in = 5'd20;
        tick(); tick();
        chk("t5_state_init", state, 2'd1);
        chk("t5_error_cleared", error, 1'b0);
        init = 1'b0;
        tick();
        chk("t5_state_idle", state, 2'd2);
        chk("t5_ae", umbral_ae, 5'd7);
        chk("t5_af", umbral_af, 5'd20);
        full_out = '0;

        // reset one cycle after a pop
        load(0, 6'h25);
        wait_pop("t6_pop_timeout", 10);
        bp = push_log.size();
        tick();
        reset_L = 1'b0;
        #1;
        chk("t6_pop", pop, 4'b0000);
        chk("t6_push", push, 4'b0000);
        chk("t6_data_out", data_out, 6'h00);
        chk("t6_state", state, 2'd0);
        chk("t6_ae", umbral_ae, 5'd0);
        chk("t6_af", umbral_af, 5'd0);
        chk("t6_idle", idle, 1'b0);
        chk("t6_error", error, 1'b0);
        repeat (3) tick();
        chk("t6_no_push", push_log.size() - bp, 0);
        reset_L = 1'b1;
        repeat (3) tick();
        chk("t6_recover_idle", state, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
